// File: rtl/lcd_text_refresh_pkg.sv
// Shared definitions for the LCD text refresher: HD44780 command bytes,
// controller state encoding and the power-up command sequence.
package lcd_text_refresh_pkg;

    localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_LINE1     = 8'h80;
    localparam logic [7:0] LCD_LINE2     = 8'hC0;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_ADDR,
        ST_FETCH,
        ST_WRITE,
        ST_NEXT
    } state_t;

    // Power-up command for a given step of the init sequence.
    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    init_cmd = LCD_FUNC_8B2L;
            2'd1:    init_cmd = LCD_DISP_ON;
            2'd2:    init_cmd = LCD_ENTRY_INC;
            default: init_cmd = LCD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_text_refresh_us_tick.sv
// Enable-clock generator: one-clock strobe every DIV system clocks.
module lcd_us_tick #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Free-running divider; the strobe is registered so it is glitch free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/lcd_text_refresh.sv
// Refreshes a 16x2 HD44780 LCD from a character source addressed by index.
// One timer counts microsecond ticks for every wait. In each bus write the
// timer value selects the phase: E rises on the second tick after the byte is
// driven (so setup is at least one full us even when entered mid-period),
// falls one tick later, and the write completes after the settle wait.
module lcd_text_refresh
    import lcd_text_refresh_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int PWRUP_MS = 20,
    parameter int CMD_US   = 50,
    parameter int CLR_US   = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    output logic [4:0] index,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       frame_done
);
    localparam int            TW         = $clog2(PWRUP_MS * 1000 + 1);
    localparam logic [TW-1:0] PWRUP_LAST = TW'(PWRUP_MS * 1000 - 1);
    localparam logic [TW-1:0] E_RISE_AT  = TW'(1);
    localparam logic [TW-1:0] E_FALL_AT  = TW'(2);
    localparam logic [TW-1:0] CMD_DONE   = TW'(CMD_US + 2);
    localparam logic [TW-1:0] CLR_DONE   = TW'(CLR_US + 2);

    logic          w_tick;
    logic [TW-1:0] w_done_at;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_init_idx;
    logic          r_fetch_cnt;
    logic [4:0]    r_index;
    logic          r_e;
    logic          r_rs;
    logic [7:0]    r_data;
    logic          r_frame_done;

    lcd_us_tick #(
        .DIV(CLK_HZ / 1_000_000)
    ) u_us_tick (
        .clk   (clk),
        .rst   (rst),
        .o_tick(w_tick)
    );

    // Clear-display needs the long settle; data bytes of 8'h01 do not.
    assign w_done_at = (!r_rs && (r_data == LCD_CLEAR)) ? CLR_DONE : CMD_DONE;

    // Controller FSM with timer, index counter and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_PWRUP;
            r_timer      <= '0;
            r_init_idx   <= 2'd0;
            r_fetch_cnt  <= 1'b0;
            r_index      <= 5'd0;
            r_e          <= 1'b0;
            r_rs         <= 1'b0;
            r_data       <= 8'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_PWRUP: begin
                    if (w_tick) begin
                        if (r_timer == PWRUP_LAST) begin
                            r_timer    <= '0;
                            r_init_idx <= 2'd0;
                            r_rs       <= 1'b0;
                            r_data     <= init_cmd(2'd0);
                            r_state    <= ST_INIT;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                ST_INIT, ST_ADDR, ST_WRITE: begin
                    if (w_tick) begin
                        if (r_timer == E_RISE_AT) begin
                            r_e     <= 1'b1;
                            r_timer <= r_timer + 1'b1;
                        end else if (r_timer == E_FALL_AT) begin
                            r_e     <= 1'b0;
                            r_timer <= r_timer + 1'b1;
                        end else if (r_timer == w_done_at) begin
                            r_timer <= '0;
                            if (r_state == ST_INIT) begin
                                if (r_init_idx == 2'd3) begin
                                    r_data  <= LCD_LINE1;
                                    r_state <= ST_ADDR;
                                end else begin
                                    r_init_idx <= r_init_idx + 2'd1;
                                    r_data     <= init_cmd(r_init_idx + 2'd1);
                                end
                            end else if (r_state == ST_ADDR) begin
                                r_fetch_cnt <= 1'b0;
                                r_state     <= ST_FETCH;
                            end else begin
                                r_state <= ST_NEXT;
                            end
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    // The source registers char_in one clock after index moves,
                    // so sample on the second clock of a stable index.
                    if (!r_fetch_cnt) begin
                        r_fetch_cnt <= 1'b1;
                    end else begin
                        r_data  <= char_in;
                        r_rs    <= 1'b1;
                        r_timer <= '0;
                        r_state <= ST_WRITE;
                    end
                end
                ST_NEXT: begin
                    if (r_index == 5'd31) begin
                        r_frame_done <= 1'b1;
                        r_index      <= 5'd0;
                        r_rs         <= 1'b0;
                        r_data       <= LCD_LINE1;
                        r_state      <= ST_ADDR;
                    end else if (r_index == 5'd15) begin
                        r_index <= 5'd16;
                        r_rs    <= 1'b0;
                        r_data  <= LCD_LINE2;
                        r_state <= ST_ADDR;
                    end else begin
                        r_index     <= r_index + 5'd1;
                        r_fetch_cnt <= 1'b0;
                        r_state     <= ST_FETCH;
                    end
                end
                default: r_state <= ST_PWRUP;
            endcase
        end
    end

    assign index      = r_index;
    assign lcd_e      = r_e;
    assign lcd_rs     = r_rs;
    assign lcd_rw     = 1'b0;
    assign lcd_data   = r_data;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_text_refresh.sv
// Bench for lcd_text_refresh at 4 MHz (1 us = 4 clks), PWRUP 1 ms, CMD 3 us,
// CLR 10 us. A bus monitor logs every completed E pulse; the main sequence
// compares the log against tables of expected command/data writes.
module tb_lcd_text_refresh;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] char_in = 8'h00;
    logic [4:0] index;
    logic       lcd_e, lcd_rs, lcd_rw, frame_done;
    logic [7:0] lcd_data;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [4:0] idx;
    } vec_t;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [4:0] idx;
        int         t_rise;
        int         t_fall;
    } wr_t;

    vec_t init_tab[4];
    vec_t frame_tab[34];
    wr_t  wq[$];
    int   fd_times[$];

    logic tamper = 1'b0;
    logic [4:0] m_prev_idx = 5'd0;

    lcd_text_refresh #(
        .CLK_HZ  (4_000_000),
        .PWRUP_MS(1),
        .CMD_US  (3),
        .CLR_US  (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .char_in   (char_in),
        .index     (index),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Character source: registered 'A'+index. With tamper set, the byte turns
    // to EE from the second clock of a stable index (the DUT's latch edge) at
    // positions reached straight from the previous one, so an early or late
    // latch writes EE.
    always @(posedge clk) begin
        m_prev_idx <= index;
        if (tamper && index == m_prev_idx && index != 5'd0 && index != 5'd16)
            char_in <= 8'hEE;
        else
            char_in <= 8'h41 + {3'b000, index};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bus protocol monitor, sampled on the falling edge.
    logic m_prev_e = 1'b0;
    int   m_hi = 0;
    logic m_unstable = 1'b0;
    logic m_rw_bad = 1'b0;
    int   fd_len = 0;
    int   fd_rise = 0;
    wr_t  m_cur;
    always @(negedge clk) begin
        if (lcd_rw !== 1'b0) m_rw_bad = 1'b1;
        if (lcd_e === 1'b1 && !m_prev_e) begin
            m_cur.rs = lcd_rs; m_cur.data = lcd_data; m_cur.idx = index;
            m_cur.t_rise = cyc; m_hi = 1; m_unstable = 1'b0;
        end else if (lcd_e === 1'b1) begin
            m_hi++;
            if (lcd_rs !== m_cur.rs || lcd_data !== m_cur.data) m_unstable = 1'b1;
        end else if (m_prev_e && !rst) begin
            m_cur.t_fall = cyc;
            wq.push_back(m_cur);
            chk("e_high_clks", 32'(m_hi), 32'd4);
            chk("bus_stable_while_e", 32'(m_unstable), 32'd0);
            chk("rw_low", 32'(m_rw_bad), 32'd0);
            m_rw_bad = 1'b0;
        end
        m_prev_e = (lcd_e === 1'b1);
        if (frame_done === 1'b1) begin
            if (fd_len == 0) fd_rise = cyc;
            fd_len++;
        end else if (fd_len != 0) begin
            chk("frame_done_width", 32'(fd_len), 32'd1);
            fd_times.push_back(fd_rise);
            fd_len = 0;
        end
    end

    task automatic wait_writes(input int n, input int budget, input string what);
        int k = 0;
        while (wq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (wq.size() < n) begin
            checks++; fails++;
            $display("FAIL %s: timeout, got %0d writes, required %0d", what, wq.size(), n);
        end
    endtask

    task automatic wait_fd(input int n, input int budget);
        int k = 0;
        while (fd_times.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (fd_times.size() < n) begin
            checks++; fails++;
            $display("FAIL frame_done_wait: got %0d pulses, required %0d", fd_times.size(), n);
        end
    endtask

    task automatic check_wr(input int k, input vec_t e, input string name);
        if (k >= wq.size()) begin
            checks++; fails++;
            $display("FAIL %s[%0d]: write missing, required rs=%b data=%h", name, k, e.rs, e.data);
        end else begin
            $display("write %0d: rs=%b data=%h idx=%0d t=%0d", k, wq[k].rs, wq[k].data, wq[k].idx, wq[k].t_rise);
            chk(name, 32'({wq[k].rs, wq[k].data, wq[k].idx}), 32'({e.rs, e.data, e.idx}));
        end
    endtask

    initial begin
        int t_rel;
        int base;
        int k;

        init_tab[0] = '{1'b0, 8'h38, 5'd0};
        init_tab[1] = '{1'b0, 8'h0C, 5'd0};
        init_tab[2] = '{1'b0, 8'h06, 5'd0};
        init_tab[3] = '{1'b0, 8'h01, 5'd0};
        frame_tab[0]  = '{1'b0, 8'h80, 5'd0};
        frame_tab[17] = '{1'b0, 8'hC0, 5'd16};
        for (int p = 0; p < 16; p++) begin
            frame_tab[1 + p]  = '{1'b1, 8'h41 + 8'(p), 5'(p)};
            frame_tab[18 + p] = '{1'b1, 8'h51 + 8'(p), 5'(p + 16)};
        end

        // Reset values
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_e", 32'(lcd_e), 32'd0);
        chk("rst_rs", 32'(lcd_rs), 32'd0);
        chk("rst_rw", 32'(lcd_rw), 32'd0);
        chk("rst_data", 32'(lcd_data), 32'h00);
        chk("rst_index", 32'(index), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);

        // Power-up wait and init sequence
        rst = 1'b0;
        t_rel = cyc;
        wait_writes(5, 6000, "init");
        for (int i = 0; i < 4; i++) check_wr(i, init_tab[i], "init_cmd");
        if (wq.size() >= 5) begin
            chk("pwrup_wait", 32'((wq[0].t_rise - t_rel) >= 4000), 32'd1);
            chk("clear_gap", 32'((wq[4].t_rise - wq[3].t_fall) >= 40), 32'd1);
        end

        // Frame 1 with a plain source, frame 2 with a tampering source
        wait_fd(1, 4000);
        tamper = 1'b1;
        wait_writes(38, 4000, "frame1");
        for (int i = 0; i < 34; i++) check_wr(4 + i, frame_tab[i], "frame1");
        if (wq.size() >= 39 && fd_times.size() >= 1) begin
            chk("fd_after_last", 32'(fd_times[0] > wq[37].t_fall), 32'd1);
            chk("fd_before_wrap", 32'(fd_times[0] < wq[38].t_rise), 32'd1);
        end
        wait_fd(2, 4000);
        tamper = 1'b0;
        wait_writes(72, 4000, "frame2");
        for (int i = 0; i < 34; i++) check_wr(38 + i, frame_tab[i], "frame2");

        // Abort a data write with reset
        k = 0;
        while (!(lcd_e === 1'b1 && lcd_rs === 1'b1) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("e_before_abort", 32'(lcd_e), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_e", 32'(lcd_e), 32'd0);
        chk("abort_data", 32'(lcd_data), 32'h00);
        chk("abort_index", 32'(index), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t_rel = cyc;
        base = wq.size();
        wait_writes(base + 1, 6000, "reinit");
        check_wr(base, init_tab[0], "reinit_cmd");
        if (wq.size() > base)
            chk("reinit_wait", 32'((wq[base].t_rise - t_rel) >= 4000), 32'd1);
        chk("frame_count", 32'(fd_times.size()), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
